// File: rtl/_bus_arbiter_pkg.sv
// Shared types and width helpers for the bus arbiter and its
// round-robin picker.
package _bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    function automatic int cnt_width(input int hold_max);
        int w;
        w = $clog2(hold_max + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above
// the pointer, wrapping modulo N, as a one-hot winner.
module _rr_pick
    import _bus_arbiter_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr) + i) % N]) begin
                win[(int'(ptr) + i) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/_bus_arbiter.sv
// Round-robin owner sequencer for the shared tri-state bus; drives
// active-low bank enables with a one-cycle all-off turnaround.
module _bus_arbiter
    import _bus_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int HOLD_MAX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] g,
    output logic [N-1:0] gnt,
    output logic         busy
);

    localparam int PW = ptr_width(N);
    localparam int CW = cnt_width(HOLD_MAX);
    localparam logic [CW-1:0] HLAST =
        (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [CW-1:0] hcnt, hcnt_n;
    logic [N-1:0]  gnt_q, gnt_n;
    logic [N-1:0]  win;
    logic          valid;
    logic [PW-1:0] win_idx, win_nxt;
    logic          own, others, at_limit;

    _rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .valid (valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
        win_nxt = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end

    assign own      = |(req & gnt_q);
    assign others   = |(req & ~gnt_q);
    assign at_limit = (HOLD_MAX > 0) && (hcnt == HLAST);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        gnt_n   = gnt_q;
        case (state)
            IDLE, TURN: begin
                gnt_n   = '0;
                state_n = IDLE;
                if (valid) begin
                    state_n = GRANT;
                    gnt_n   = win;
                    ptr_n   = win_nxt;
                    hcnt_n  = '0;
                end
            end
            GRANT: begin
                if (!own || (at_limit && others)) begin
                    state_n = TURN;
                    gnt_n   = '0;
                end else if (HOLD_MAX > 0 && !at_limit) begin
                    // saturates at the limit while nobody else waits
                    hcnt_n = hcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            hcnt  <= '0;
            gnt_q <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hcnt  <= hcnt_n;
            gnt_q <= gnt_n;
        end
    end

    assign gnt  = gnt_q;
    assign g    = ~gnt_q;
    assign busy = (state == GRANT);

endmodule

// File: tb/tb__bus_arbiter.sv
// Directed scoreboard bench for _bus_arbiter: N=8 unlimited hold,
// N=8 with HOLD_MAX=4, and N=1.
module tb__bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_a = '0, g_a, gnt_a;
    logic [7:0] req_b = '0, g_b, gnt_b;
    logic       req_c = 1'b0, g_c, gnt_c;
    logic       busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] g;
        logic       busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    _bus_arbiter #(.N(8), .HOLD_MAX(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .g(g_a), .gnt(gnt_a), .busy(busy_a)
    );

    _bus_arbiter #(.N(8), .HOLD_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .g(g_b), .gnt(gnt_b), .busy(busy_b)
    );

    _bus_arbiter #(.N(1), .HOLD_MAX(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c),
        .g(g_c), .gnt(gnt_c), .busy(busy_c)
    );

    // every-cycle bus safety: one owner, gnt mirrors g, no back-to-back owners
    logic [7:0] pa = '0, pb = '0;
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            assert ($countones(~g_a) <= 1 && gnt_a === ~g_a) else begin
                errors++;
                $error("FAIL onehot_a: g=%h gnt=%h required <=1 low and gnt==~g",
                       g_a, gnt_a);
            end
            checks++;
            assert ($countones(~g_b) <= 1 && gnt_b === ~g_b) else begin
                errors++;
                $error("FAIL onehot_b: g=%h gnt=%h required <=1 low and gnt==~g",
                       g_b, gnt_b);
            end
            checks++;
            assert (gnt_c === ~g_c) else begin
                errors++;
                $error("FAIL mirror_c: g=%b gnt=%b required gnt==~g", g_c, gnt_c);
            end
            checks++;
            assert (!(|pa && |gnt_a && pa != gnt_a)) else begin
                errors++;
                $error("FAIL adjacent_a: prev=%h now=%h required gap cycle",
                       pa, gnt_a);
            end
            checks++;
            assert (!(|pb && |gnt_b && pb != gnt_b)) else begin
                errors++;
                $error("FAIL adjacent_b: prev=%h now=%h required gap cycle",
                       pb, gnt_b);
            end
            pa = gnt_a;
            pb = gnt_b;
        end
    end

    task automatic check_out();
        exp_t       e;
        string      t;
        logic [7:0] og;
        logic       ob;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        case (e.inst)
            2'd0:    begin og = g_a; ob = busy_a; end
            2'd1:    begin og = g_b; ob = busy_b; end
            default: begin og = {7'h7f, g_c}; ob = busy_c; end
        endcase
        checks++;
        assert (og === e.g) else begin
            errors++;
            $error("FAIL %s g: got %h required %h", t, og, e.g);
        end
        checks++;
        assert (ob === e.busy) else begin
            errors++;
            $error("FAIL %s busy: got %b required %b", t, ob, e.busy);
        end
    endtask

    task automatic push(input logic [1:0] inst, input logic [7:0] eg,
                        input logic eb, input string tag);
        exp_t e;
        e.inst = inst;
        e.g    = eg;
        e.busy = eb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step(input logic [1:0] inst, input logic [7:0] r,
                        input logic [7:0] eg, input logic eb,
                        input string tag);
        case (inst)
            2'd0:    req_a = r;
            2'd1:    req_b = r;
            default: req_c = r[0];
        endcase
        push(inst, eg, eb, tag);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = 1'b0;
        push(2'd0, 8'hFF, 1'b0, "reset_a");
        push(2'd1, 8'hFF, 1'b0, "reset_b");
        push(2'd2, 8'hFF, 1'b0, "reset_c");
        @(posedge clk);
        #1;
        check_out();
        check_out();
        check_out();
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;

        // single requester: grant, hold, release, turnaround, idle
        do_reset();
        step(2'd0, 8'h04, 8'hFB, 1'b1, "t1_grant");
        step(2'd0, 8'h04, 8'hFB, 1'b1, "t1_hold1");
        step(2'd0, 8'h04, 8'hFB, 1'b1, "t1_hold2");
        step(2'd0, 8'h00, 8'hFF, 1'b0, "t1_turn");
        step(2'd0, 8'h00, 8'hFF, 1'b0, "t1_idle");

        // all requesting, each owner leaves after 2 cycles: order 0..7,0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            m = 8'h01 << (k % 8);
            step(2'd0, 8'hFF, ~m, 1'b1, "rr_grant");
            step(2'd0, 8'hFF, ~m, 1'b1, "rr_hold");
            step(2'd0, 8'hFF & ~m, 8'hFF, 1'b0, "rr_turn");
        end

        // hold limit 4 with two competitors
        do_reset();
        for (int i = 0; i < 4; i++)
            step(2'd1, 8'h28, 8'hF7, 1'b1, "t3_bank3");
        step(2'd1, 8'h28, 8'hFF, 1'b0, "t3_turn1");
        for (int i = 0; i < 4; i++)
            step(2'd1, 8'h28, 8'hDF, 1'b1, "t3_bank5");
        step(2'd1, 8'h28, 8'hFF, 1'b0, "t3_turn2");
        step(2'd1, 8'h28, 8'hF7, 1'b1, "t3_back3");

        // hold limit 4 with no competitor: no forced release
        do_reset();
        for (int i = 0; i < 20; i++)
            step(2'd1, 8'h04, 8'hFB, 1'b1, "t4_solo");
        step(2'd1, 8'h00, 8'hFF, 1'b0, "t4_release");

        // reset mid-grant returns the pointer to 0
        do_reset();
        step(2'd0, 8'h40, 8'hBF, 1'b1, "t5_grant6");
        step(2'd0, 8'h40, 8'hBF, 1'b1, "t5_hold6");
        rst = 1'b1;
        step(2'd0, 8'h40, 8'hFF, 1'b0, "t5_rst");
        rst = 1'b0;
        step(2'd0, 8'hC0, 8'hBF, 1'b1, "t5_ptr0");

        // single bank: turnaround still present
        do_reset();
        step(2'd2, 8'h01, 8'hFE, 1'b1, "n1_grant");
        step(2'd2, 8'h01, 8'hFE, 1'b1, "n1_hold");
        step(2'd2, 8'h00, 8'hFF, 1'b0, "n1_turn");
        step(2'd2, 8'h00, 8'hFF, 1'b0, "n1_idle");
        step(2'd2, 8'h01, 8'hFE, 1'b1, "n1_regrant");
        step(2'd2, 8'h00, 8'hFF, 1'b0, "n1_turn2");
        step(2'd2, 8'h01, 8'hFE, 1'b1, "n1_fromturn");

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
